exu_wb_arb: RTL

- Write-back arbiter between the execute-stage result producers and the single register-file write port.
- Accepts the ALU's unconditioned single-cycle write requests (result, write enable, destination address) into a small FIFO.
- Accepts long-latency LSU/MDU results through a valid/ready handshake.
- Serialises both onto one registered write port, with a starvation guard and interrupt flush.

---
 rtl/exu_wb_arb_pkg.sv | 31 +++
 rtl/exu_wb_arb_wb_sync_fifo.sv | 74 +++++++
 rtl/exu_wb_arb.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/exu_wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exu_wb_arb_pkg
// Description : Shared widths, write-enable levels, interrupt level and
//               write-back arbiter state encodings for the execute-stage
//               write-back path.
// Revision    : 1.0 - initial release
// ============================================================================
package exu_wb_arb_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;

    // Level of int_assert_i that requests a pipeline flush
    localparam logic INT_ASSERT = 1'b1;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // Write-back arbiter states
    localparam logic [0:0] WB_S_ALU       = 1'b0;
    localparam logic [0:0] WB_S_LSU_FORCE = 1'b1;

    // One pending register-file write
    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] waddr;
        logic [REG_DATA_WIDTH-1:0] wdata;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/exu_wb_arb_wb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_sync_fifo
// Description : Parameterised synchronous FIFO with flush. A push while full
//               is accepted only when a pop happens in the same cycle.
//               Ports: clk, rst (sync, active-high), push/wdata, pop, flush
//               in; head (oldest entry), count, full, empty out. count, full
//               and empty are all registered.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_pop_ok;
    logic             w_push_ok;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_pop_ok  = pop & ~r_empty;
    // A simultaneous pop frees the slot the push needs
    assign w_push_ok = push & (~r_full | w_pop_ok);

    assign w_count_nxt = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);

    // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= wdata;
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = r_full;
    assign empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/exu_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : exu_wb_arb
// Description : Write-back arbiter between the ALU (single-cycle, no
//               backpressure, buffered in a small FIFO) and long-latency
//               LSU/MDU results (valid/ready) onto one registered
//               register-file write port, with starvation guard for the
//               LSU side and interrupt flush.
//               Ports: clk, rst; alu_we_i/alu_waddr_i/alu_wdata_i;
//               lsu_valid_i/lsu_waddr_i/lsu_wdata_i -> lsu_ready_o;
//               int_assert_i; reg_we_o/reg_waddr_o/reg_wdata_o;
//               alu_full_o, alu_ovf_o (sticky), wb_idle_o.
// Revision    : 1.0 - initial release
// ============================================================================
module exu_wb_arb
    import exu_wb_arb_pkg::*;
#(
    parameter int ALU_FIFO_DEPTH = 4,
    parameter int STARVE_MAX     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] alu_waddr_i,
    input  logic [REG_DATA_WIDTH-1:0] alu_wdata_i,
    input  logic                      lsu_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] lsu_waddr_i,
    input  logic [REG_DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                      lsu_ready_o,
    input  logic                      int_assert_i,
    output logic                      reg_we_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o,
    output logic [REG_DATA_WIDTH-1:0] reg_wdata_o,
    output logic                      alu_full_o,
    output logic                      alu_ovf_o,
    output logic                      wb_idle_o
);

    localparam int REQ_W = $bits(wb_req_t);
    localparam int CNT_W = $clog2(STARVE_MAX+1);
    localparam int FCNT_W = $clog2(ALU_FIFO_DEPTH+1);

    logic [0:0]                r_state;
    logic [CNT_W-1:0]          r_starve_cnt;
    logic                      r_reg_we;
    logic [REG_ADDR_WIDTH-1:0] r_reg_waddr;
    logic [REG_DATA_WIDTH-1:0] r_reg_wdata;
    logic                      r_ovf;

    logic                      w_int;
    logic                      w_alu_live;
    logic                      w_alu_src;
    wb_req_t                   w_alu_head;
    wb_req_t                   w_fifo_head;
    logic [REQ_W-1:0]          w_fifo_head_raw;
    logic [FCNT_W-1:0]         w_fifo_count;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      w_grant_alu;
    logic                      w_grant_lsu;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_drop;
    logic [CNT_W-1:0]          w_starve_inc;

    assign w_int      = (int_assert_i == INT_ASSERT);
    // Writes to x0 never enter the arbiter
    assign w_alu_live = alu_we_i & (alu_waddr_i != '0);

    // Buffered ALU writes are always older than the live one, so the FIFO
    // head takes precedence; the live inputs bypass only when it is empty.
    assign w_fifo_head = wb_req_t'(w_fifo_head_raw);
    assign w_alu_src   = ~w_fifo_empty | w_alu_live;
    assign w_alu_head  = w_fifo_empty ? wb_req_t'{waddr: alu_waddr_i, wdata: alu_wdata_i}
                                      : w_fifo_head;

    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_lsu = 1'b0;
        if (!w_int) begin
            case (r_state)
                WB_S_ALU: begin
                    if (w_alu_src)        w_grant_alu = 1'b1;
                    else if (lsu_valid_i) w_grant_lsu = 1'b1;
                end
                WB_S_LSU_FORCE: w_grant_lsu = lsu_valid_i;
                default: ;
            endcase
        end
    end

    // Every live ALU write is buffered unless it is the one going straight out
    assign w_push = w_alu_live & ~w_int & ~(w_fifo_empty & w_grant_alu);
    assign w_pop  = ~w_fifo_empty & w_grant_alu;
    assign w_drop = w_push & w_fifo_full & ~w_pop;

    assign lsu_ready_o  = lsu_valid_i & w_grant_lsu;
    assign w_starve_inc = r_starve_cnt + CNT_W'(1);

    wb_sync_fifo #(
        .DEPTH (ALU_FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata ({alu_waddr_i, alu_wdata_i}),
        .pop   (w_pop),
        .flush (w_int),
        .head  (w_fifo_head_raw),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= WB_S_ALU;
            r_starve_cnt <= '0;
            r_reg_we     <= WRITE_DISABLE;
            r_reg_waddr  <= '0;
            r_reg_wdata  <= '0;
            r_ovf        <= 1'b0;
        end else if (w_int) begin
            // Overflow history survives the flush on purpose
            r_state      <= WB_S_ALU;
            r_starve_cnt <= '0;
            r_reg_we     <= WRITE_DISABLE;
        end else begin
            if (w_drop) r_ovf <= 1'b1;

            case (r_state)
                WB_S_ALU: begin
                    // Count only ALU wins that made a waiting LSU result wait
                    if (w_grant_alu && lsu_valid_i) begin
                        r_starve_cnt <= w_starve_inc;
                        if (w_starve_inc == CNT_W'(STARVE_MAX)) r_state <= WB_S_LSU_FORCE;
                    end else begin
                        r_starve_cnt <= '0;
                    end
                end
                default: begin
                    // One forced slot, taken or not, then back to ALU priority
                    r_state      <= WB_S_ALU;
                    r_starve_cnt <= '0;
                end
            endcase

            if (w_grant_alu) begin
                r_reg_we    <= WRITE_ENABLE;
                r_reg_waddr <= w_alu_head.waddr;
                r_reg_wdata <= w_alu_head.wdata;
            end else if (w_grant_lsu && (lsu_waddr_i != '0)) begin
                r_reg_we    <= WRITE_ENABLE;
                r_reg_waddr <= lsu_waddr_i;
                r_reg_wdata <= lsu_wdata_i;
            end else begin
                r_reg_we    <= WRITE_DISABLE;
            end
        end
    end

    assign reg_we_o    = r_reg_we;
    assign reg_waddr_o = r_reg_waddr;
    assign reg_wdata_o = r_reg_wdata;
    assign alu_full_o  = w_fifo_full;
    assign alu_ovf_o   = r_ovf;
    // Built only from flops: FIFO count and the write-enable register
    assign wb_idle_o   = (w_fifo_count == '0) & ~r_reg_we;

endmodule
`default_nettype wire
